// File: rtl/hazard_stall_controller_if.sv
//------------------------------------------------------------------------------
// Module      : hazard_stall_controller_if
// Description : Hazard inputs and pipeline-register controls of the hazard/stall
//               controller. Counter ports exist only when HAZARD_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IDrs1addr_i;
    logic [4:0]       IDrs2addr_i;
    logic             IDrs1used_i;
    logic             IDrs2used_i;
    logic             EXMemRead_i;
    logic [4:0]       EXRDaddr_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             id_ex_write_o;
    logic             ex_mem_write_o;
    logic             mem_wb_bubble_o;
    logic             halt_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] wait_cnt_o;
`endif

    modport slave (
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt_o, flush_cnt_o, wait_cnt_o,
`endif
        input  IDrs1addr_i, IDrs2addr_i, IDrs1used_i, IDrs2used_i,
        input  EXMemRead_i, EXRDaddr_i, branch_taken_i, mem_req_i, dmem_ready_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
        output id_ex_write_o, ex_mem_write_o, mem_wb_bubble_o, halt_o
    );

    modport master (
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt_o, flush_cnt_o, wait_cnt_o,
`endif
        output IDrs1addr_i, IDrs2addr_i, IDrs1used_i, IDrs2used_i,
        output EXMemRead_i, EXRDaddr_i, branch_taken_i, mem_req_i, dmem_ready_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
        input  id_ex_write_o, ex_mem_write_o, mem_wb_bubble_o, halt_o
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
//------------------------------------------------------------------------------
// Module      : hazard_stall_controller
// Description : Load-use stall, branch flush and data-memory freeze/timeout control
//               for a 5-stage pipeline. Optional counters: define HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    hazard_stall_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_freeze;
    logic w_halted;
    logic w_stall_evt;
    logic w_flush_evt;
    logic w_freeze_evt;

    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_id_ex_write;
    logic w_ex_mem_write;
    logic w_mem_wb_bubble;
    logic w_halt;

    assign w_rs1_hit  = bus.IDrs1used_i && (bus.EXRDaddr_i == bus.IDrs1addr_i);
    assign w_rs2_hit  = bus.IDrs2used_i && (bus.EXRDaddr_i == bus.IDrs2addr_i);
    // A load targeting x0 never produces a value, so it cannot be a hazard source.
    assign w_load_use = bus.EXMemRead_i && (bus.EXRDaddr_i != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_freeze   = bus.mem_req_i && !bus.dmem_ready_i;
    assign w_halted   = (r_state == S_HALT);

    assign w_freeze_evt = !w_halted && w_freeze;
    assign w_stall_evt  = !w_halted && !w_freeze && w_load_use;
    assign w_flush_evt  = !w_halted && !w_freeze && !w_load_use && bus.branch_taken_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_id_ex_write   = 1'b1;
        w_ex_mem_write  = 1'b1;
        w_mem_wb_bubble = 1'b0;
        w_halt          = 1'b0;

        case (r_state)
            S_HALT: begin
                w_pc_write      = 1'b0;
                w_if_id_write   = 1'b0;
                w_id_ex_write   = 1'b0;
                w_ex_mem_write  = 1'b0;
                w_mem_wb_bubble = 1'b1;
                w_halt          = 1'b1;
            end
            default: begin
                if (w_freeze) begin
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_id_ex_write   = 1'b0;
                    w_ex_mem_write  = 1'b0;
                    w_mem_wb_bubble = 1'b1;
                    if (r_state != S_MEM_WAIT) begin
                        w_state_nxt    = S_MEM_WAIT;
                        w_wait_cnt_nxt = 8'd1;
                    end else if (r_wait_cnt == C_TIMEOUT) begin
                        w_state_nxt    = S_HALT;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    // Access finished (or none pending): this is an ordinary RUN cycle.
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                    if (w_load_use) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                    end else if (bus.branch_taken_i) begin
                        w_if_id_flush  = 1'b1;
                    end
                end
            end
        endcase

        // Reset keeps the pipe filled with bubbles regardless of state.
        if (rst_i) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_id_ex_write   = 1'b1;
            w_ex_mem_write  = 1'b1;
            w_mem_wb_bubble = 1'b1;
            w_halt          = 1'b0;
        end
    end

    assign bus.pc_write_o      = w_pc_write;
    assign bus.if_id_write_o   = w_if_id_write;
    assign bus.if_id_flush_o   = w_if_id_flush;
    assign bus.id_ex_bubble_o  = w_id_ex_bubble;
    assign bus.id_ex_write_o   = w_id_ex_write;
    assign bus.ex_mem_write_o  = w_ex_mem_write;
    assign bus.mem_wb_bubble_o = w_mem_wb_bubble;
    assign bus.halt_o          = w_halt;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_freeze_evt && (r_freeze_cnt != '1)) begin
                r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
    assign bus.wait_cnt_o  = r_freeze_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_stall_evt ^ w_flush_evt ^ w_freeze_evt;
`endif

endmodule

`default_nettype wire
